// File: rtl/uart_rx_core.sv
// UART receiver: 2-flop synchroniser, mid-bit 3-sample majority vote, configurable
// data/parity/stop framing, with DV/CLR_DV handshake and parity/framing/overrun flags.
module uart_rx_core #(
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 RX,
  input  logic                 CLR_DV,
  output logic [DATA_BITS-1:0] DATA,
  output logic                 DV,
  output logic                 PE,
  output logic                 FE,
  output logic                 OE,
  output logic                 BUSY
);

  localparam int unsigned H       = CLKS_PER_BIT / 2;
  localparam int unsigned HAS_PAR = (PARITY != 0) ? 1 : 0;
  localparam int unsigned NBITS   = 1 + DATA_BITS + HAS_PAR + STOP_BITS;
  localparam int unsigned TW      = $clog2(CLKS_PER_BIT);
  localparam int unsigned BW      = $clog2(NBITS);

  localparam logic [TW-1:0] T_S0   = TW'(H - 1);
  localparam logic [TW-1:0] T_S1   = TW'(H);
  localparam logic [TW-1:0] T_DEC  = TW'(H + 1);
  localparam logic [TW-1:0] T_WRAP = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] B_LAST_DATA = BW'(DATA_BITS);
  localparam logic [BW-1:0] B_LAST      = BW'(NBITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_BREAK
  } state_t;

  state_t               state_q, state_d;
  logic                 sync1_q, sync2_q;
  logic [TW-1:0]        timer_q;
  logic [BW-1:0]        bit_q;
  logic                 s0_q, s1_q;
  logic [DATA_BITS-1:0] shift_q, data_q;
  logic                 par_q, stop_err_q;
  logic                 dv_q, pe_q, fe_q, oe_q;

  logic rx_s, busy, dec, maj, done, pe_calc;

  assign rx_s = sync2_q;
  // Third vote is the live synchronised line at the decision tick.
  assign maj  = (s0_q & s1_q) | (s0_q & rx_s) | (s1_q & rx_s);
  assign dec  = busy && (timer_q == T_DEC);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!rx_s) state_d = S_START;
      S_START: if (dec) state_d = maj ? S_IDLE : S_DATA;
      S_DATA:  if (dec && bit_q == B_LAST_DATA) state_d = (HAS_PAR != 0) ? S_PAR : S_STOP;
      S_PAR:   if (dec) state_d = S_STOP;
      S_STOP:  if (dec && bit_q == B_LAST) state_d = (stop_err_q | ~maj) ? S_BREAK : S_IDLE;
      S_BREAK: if (rx_s) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q == S_START) || (state_q == S_DATA) ||
              (state_q == S_PAR)   || (state_q == S_STOP);
    done    = (state_q == S_STOP) && dec && (bit_q == B_LAST);
    pe_calc = (PARITY == 0) ? 1'b0 : ((^shift_q) ^ par_q ^ (PARITY == 1));
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      timer_q    <= '0;
      bit_q      <= '0;
      s0_q       <= 1'b1;
      s1_q       <= 1'b1;
      shift_q    <= '0;
      par_q      <= 1'b0;
      stop_err_q <= 1'b0;
      data_q     <= '0;
      dv_q       <= 1'b0;
      pe_q       <= 1'b0;
      fe_q       <= 1'b0;
      oe_q       <= 1'b0;
    end else begin
      sync1_q <= RX;
      sync2_q <= sync1_q;

      // Timer idles at zero so it is already cleared on entry to START.
      if (!busy) begin
        timer_q <= '0;
        bit_q   <= '0;
      end else if (timer_q == T_WRAP) begin
        timer_q <= '0;
        bit_q   <= bit_q + 1'b1;
      end else begin
        timer_q <= timer_q + 1'b1;
      end

      if (busy && timer_q == T_S0) s0_q <= rx_s;
      if (busy && timer_q == T_S1) s1_q <= rx_s;

      if (state_q == S_DATA && dec) shift_q <= {maj, shift_q[DATA_BITS-1:1]};
      if (state_q == S_PAR && dec)  par_q   <= maj;

      if (state_q == S_IDLE)                    stop_err_q <= 1'b0;
      else if (state_q == S_STOP && dec && !maj) stop_err_q <= 1'b1;

      if (done) begin
        data_q <= shift_q;
        pe_q   <= pe_calc;
        fe_q   <= stop_err_q | ~maj;
        dv_q   <= 1'b1;
        oe_q   <= dv_q & ~CLR_DV;
      end else if (CLR_DV) begin
        dv_q <= 1'b0;
        oe_q <= 1'b0;
      end
    end
  end

  assign DATA = data_q;
  assign DV   = dv_q;
  assign PE   = pe_q;
  assign FE   = fe_q;
  assign OE   = oe_q;
  assign BUSY = busy;

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: an 8N1 and an 8E2 receiver driven by directed and random frames,
// checked every cycle against a frame-level model of completion edges and handshake flags.
module tb_uart_rx_core;

  localparam int unsigned C = 16;
  localparam int unsigned H = C / 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx     [2];
  logic       clr    [2];
  logic [7:0] data_o [2];
  logic       dv_o   [2];
  logic       pe_o   [2];
  logic       fe_o   [2];
  logic       oe_o   [2];
  logic       busy_o [2];

  always #5 clk = ~clk;

  uart_rx_core #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .CLKS_PER_BIT(C)) u_8n1 (
    .CLK(clk), .RST(rst), .RX(rx[0]), .CLR_DV(clr[0]), .DATA(data_o[0]),
    .DV(dv_o[0]), .PE(pe_o[0]), .FE(fe_o[0]), .OE(oe_o[0]), .BUSY(busy_o[0]));

  uart_rx_core #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .CLKS_PER_BIT(C)) u_8e2 (
    .CLK(clk), .RST(rst), .RX(rx[1]), .CLR_DV(clr[1]), .DATA(data_o[1]),
    .DV(dv_o[1]), .PE(pe_o[1]), .FE(fe_o[1]), .OE(oe_o[1]), .BUSY(busy_o[1]));

  typedef struct {
    int unsigned bstart;
    int unsigned done;
    bit          frame;
    logic [7:0]  d;
    bit          pe;
    bit          fe;
  } ev_t;

  ev_t         evq [2][$];
  int unsigned cyc = 0;
  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned last_e0 = 0;
  bit          e_dv [2], e_pe [2], e_fe [2], e_oe [2], e_busy [2];
  logic [7:0]  e_data [2];
  int unsigned dv_rise [2], busy_rise [2], busy_fall [2];
  bit          dv_p [2], busy_p [2];

  // Frame length in bit periods: start + data + parity + stops.
  function automatic int unsigned nbits(input int i);
    return (i == 0) ? (1 + 8 + 0 + 1) : (1 + 8 + 1 + 2);
  endfunction

  always @(posedge clk) begin
    cyc = cyc + 1;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        evq[i].delete();
        e_dv[i] = 0; e_pe[i] = 0; e_fe[i] = 0; e_oe[i] = 0; e_busy[i] = 0;
        e_data[i] = '0;
      end else begin
        if (evq[i].size() > 0 && evq[i][0].done == cyc && evq[i][0].frame) begin
          e_oe[i]   = e_dv[i] & ~clr[i];
          e_dv[i]   = 1;
          e_data[i] = evq[i][0].d;
          e_pe[i]   = evq[i][0].pe;
          e_fe[i]   = evq[i][0].fe;
        end else if (clr[i]) begin
          e_dv[i] = 0;
          e_oe[i] = 0;
        end
        if (evq[i].size() > 0 && evq[i][0].done == cyc) void'(evq[i].pop_front());
        e_busy[i] = (evq[i].size() > 0) && (cyc >= evq[i][0].bstart);
      end
    end
  end

  always @(negedge clk) begin
    logic [12:0] got, exp;
    for (int i = 0; i < 2; i++) begin
      got = {dv_o[i], pe_o[i], fe_o[i], oe_o[i], busy_o[i], data_o[i]};
      exp = rst ? 13'd0 : {e_dv[i], e_pe[i], e_fe[i], e_oe[i], e_busy[i], e_data[i]};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL outputs inst%0d cyc %0d: got dv,pe,fe,oe,busy=%b data=%h, expected %b data=%h",
                 i, cyc, got[12:8], got[7:0], exp[12:8], exp[7:0]);
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (dv_o[i] === 1'b1 && !dv_p[i]) dv_rise[i] = cyc;
      if (busy_o[i] === 1'b1 && !busy_p[i]) busy_rise[i] = cyc;
      if (busy_o[i] === 1'b0 && busy_p[i]) busy_fall[i] = cyc;
      dv_p[i]   = (dv_o[i] === 1'b1);
      busy_p[i] = (busy_o[i] === 1'b1);
    end
  end

  task automatic chk(input string nm, input int unsigned got, input int unsigned exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, got, got, exp, exp);
    end
  endtask

  task automatic idle(input int unsigned n, input int unsigned clr_pct);
    for (int unsigned s = 0; s < n; s++) begin
      rx[0] = 1'b1; rx[1] = 1'b1;
      clr[0] = ($urandom_range(0, 99) < clr_pct);
      clr[1] = ($urandom_range(0, 99) < clr_pct);
      @(posedge clk); #1;
    end
    clr[0] = 1'b0; clr[1] = 1'b0;
  endtask

  task automatic pulse_clr(input int i);
    clr[i] = 1'b1;
    @(posedge clk); #1;
    clr[i] = 1'b0;
  endtask

  // gbit/gslot invert one sample slot of one bit; clr_done raises CLR_DV only in the completion cycle.
  task automatic send(input int i, input logic [7:0] d, input logic pb, input logic [1:0] st,
                      input int gbit, input int gslot, input int unsigned clr_pct, input bit clr_done);
    int unsigned n, e0, done;
    logic [11:0] bits;
    logic        v;
    bit          pe, fe;
    n    = nbits(i);
    bits = (i == 0) ? {2'b11, st[0], d, 1'b0} : {st[1], st[0], pb, d, 1'b0};
    pe   = (i == 1) ? ((^d) ^ pb) : 1'b0;
    fe   = (i == 1) ? ~(st[0] & st[1]) : ~st[0];
    e0   = cyc + 1;
    done = e0 + (n - 1) * C + H + 4;
    last_e0 = e0;
    evq[i].push_back('{bstart: e0 + 2, done: done, frame: 1'b1, d: d, pe: pe, fe: fe});
    for (int b = 0; b < int'(n); b++) begin
      for (int j = 0; j < int'(C); j++) begin
        v = bits[b];
        if (b == gbit && j == gslot) v = ~v;
        rx[i]  = v;
        clr[i] = clr_done ? (cyc + 1 == done) : ($urandom_range(0, 99) < clr_pct);
        @(posedge clk); #1;
      end
    end
    rx[i]  = 1'b1;
    clr[i] = 1'b0;
  endtask

  // Low pulse of len cycles on an idle line: rejected at the start-bit vote.
  task automatic pulse(input int i, input int unsigned len);
    int unsigned e0;
    e0 = cyc + 1;
    last_e0 = e0;
    evq[i].push_back('{bstart: e0 + 2, done: e0 + H + 4, frame: 1'b0, d: 8'h00, pe: 1'b0, fe: 1'b0});
    for (int unsigned s = 0; s < H + 6; s++) begin
      rx[i] = (s < len) ? 1'b0 : 1'b1;
      @(posedge clk); #1;
    end
    rx[i] = 1'b1;
  endtask

  initial begin
    #2_000_000;
    miscompares++;
    $display("FAIL watchdog: got no end of stimulus, expected finish before 2 ms");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned e0;
    logic [9:0]  fb;
    rx[0] = 1'b1; rx[1] = 1'b1; clr[0] = 1'b0; clr[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_dv", dv_o[0], 0);
    chk("reset_data", data_o[1], 0);
    chk("reset_busy", busy_o[0], 0);
    rst = 1'b0;
    idle(5, 0);

    send(0, 8'hA5, 1'b0, 2'b11, -1, 0, 0, 1'b0);
    chk("a5_data", data_o[0], 8'hA5);
    chk("a5_dv", dv_o[0], 1);
    chk("a5_pe", pe_o[0], 0);
    chk("a5_fe", fe_o[0], 0);
    chk("a5_oe", oe_o[0], 0);
    chk("a5_dv_latency", dv_rise[0] - last_e0, 156);
    chk("a5_busy_latency", busy_rise[0] - last_e0, 2);
    pulse_clr(0);
    chk("a5_clr_dv", dv_o[0], 0);

    send(1, 8'h07, 1'b0, 2'b11, -1, 0, 0, 1'b0);
    chk("par_bad_data", data_o[1], 8'h07);
    chk("par_bad_pe", pe_o[1], 1);
    idle(3, 0);
    send(1, 8'h07, 1'b1, 2'b11, -1, 0, 0, 1'b0);
    chk("par_good_pe", pe_o[1], 0);

    send(0, 8'h55, 1'b0, 2'b11, 4, H + 1, 0, 1'b0);
    chk("glitch_data", data_o[0], 8'h55);

    pulse_clr(0);
    pulse(0, 6);
    chk("pulse_dv", dv_o[0], 0);
    chk("pulse_busy_rise", busy_rise[0] - last_e0, 2);
    chk("pulse_busy_fall", busy_fall[0] - last_e0, H + 4);
    idle(5, 0);

    send(0, 8'h11, 1'b0, 2'b11, -1, 0, 0, 1'b0);
    idle(4, 0);
    send(0, 8'h22, 1'b0, 2'b11, -1, 0, 0, 1'b0);
    chk("ovr_data", data_o[0], 8'h22);
    chk("ovr_oe", oe_o[0], 1);
    pulse_clr(0);
    chk("ovr_clr_oe", oe_o[0], 0);
    send(0, 8'h11, 1'b0, 2'b11, -1, 0, 0, 1'b0);
    idle(4, 0);
    send(0, 8'h22, 1'b0, 2'b11, -1, 0, 0, 1'b1);
    chk("ovr_win_dv", dv_o[0], 1);
    chk("ovr_win_oe", oe_o[0], 0);

    pulse_clr(0);
    send(0, 8'hC3, 1'b0, 2'b11, -1, 0, 0, 1'b0);
    send(0, 8'h3A, 1'b0, 2'b11, -1, 0, 0, 1'b0);
    chk("b2b_data", data_o[0], 8'h3A);
    chk("b2b_oe", oe_o[0], 1);

    pulse_clr(0);
    idle(4, 0);
    e0 = cyc + 1;
    last_e0 = e0;
    evq[0].push_back('{bstart: e0 + 2, done: e0 + 156, frame: 1'b1, d: 8'h00, pe: 1'b0, fe: 1'b1});
    for (int unsigned s = 0; s < 30 * C; s++) begin
      rx[0]  = 1'b0;
      clr[0] = (s == 200);
      @(posedge clk); #1;
    end
    clr[0] = 1'b0;
    chk("brk_dv_latency", dv_rise[0] - last_e0, 156);
    chk("brk_data", data_o[0], 8'h00);
    chk("brk_fe", fe_o[0], 1);
    chk("brk_no_second_dv", dv_o[0], 0);
    chk("brk_busy", busy_o[0], 0);
    idle(10, 0);

    send(0, 8'h81, 1'b0, 2'b11, -1, 0, 0, 1'b0);
    fb = {1'b1, 8'h3C, 1'b0};
    e0 = cyc + 1;
    evq[0].push_back('{bstart: e0 + 2, done: e0 + 156, frame: 1'b1, d: 8'h3C, pe: 1'b0, fe: 1'b0});
    for (int unsigned s = 0; s < 5 * C + 8; s++) begin
      rx[0] = fb[s / C];
      @(posedge clk); #1;
    end
    chk("rst_pre_busy", busy_o[0], 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_dv", dv_o[0], 0);
    chk("rst_async_data", data_o[0], 0);
    chk("rst_async_busy", busy_o[0], 0);
    rx[0] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    idle(5, 0);
    send(0, 8'h3C, 1'b0, 2'b11, -1, 0, 0, 1'b0);
    chk("rst_after_data", data_o[0], 8'h3C);
    chk("rst_after_fe", fe_o[0], 0);
    chk("rst_after_dv", dv_o[0], 1);

    for (int k = 0; k < 60; k++) begin
      int          i, gbit, gslot;
      logic [7:0]  d;
      logic [1:0]  st;
      logic        pb;
      int unsigned pct;
      i  = int'($urandom_range(0, 1));
      d  = 8'($urandom);
      pb = 1'($urandom);
      st = ($urandom_range(0, 99) < 80) ? 2'b11 : 2'($urandom);
      gbit = -1;
      gslot = 0;
      if ($urandom_range(0, 1) == 1) begin
        gbit  = int'($urandom_range(1, 8));
        gslot = ($urandom_range(0, 1) == 1) ? int'($urandom_range(H, H + 2))
                                            : int'($urandom_range(0, C - 1));
      end
      case ($urandom_range(0, 2))
        0:       pct = 0;
        1:       pct = 5;
        default: pct = 30;
      endcase
      send(i, d, pb, st, gbit, gslot, pct, 1'b0);
      if (st != 2'b11 || $urandom_range(0, 2) != 0) idle($urandom_range(2, 20), pct);
      if ($urandom_range(0, 4) == 0) begin
        pulse(int'($urandom_range(0, 1)), $urandom_range(1, H));
        idle($urandom_range(0, 5), 0);
      end
    end
    idle(30, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
